// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store sequencer (master) and memory (slave).
// Request fields are held stable while busReq is high; busRdata is valid with busAck.
interface lsu_ctrl_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busStrb;
  logic        busAck;
  logic [31:0] busRdata;

  modport master (
    output busReq, busWe, busAddr, busWdata, busStrb,
    input  busAck, busRdata
  );

  modport slave (
    input  busReq, busWe, busAddr, busWdata, busStrb,
    output busAck, busRdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one single-word bus transaction per request, with strobes, lane
// replication, load alignment/extension and error detection. Macro LSU_TIMEOUT_EN adds an ack timeout.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memReq,
  input  logic        memWe,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        doneValid,
  output logic [31:0] rdata,
  output logic        errValid,
  output logic [1:0]  errCode,
  lsu_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10,
    ERR   = 2'b11
  } state_t;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("lsu_ctrl: TIMEOUT_CYC must be in 1..255");
  end

  state_t      state_r;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        busy_r;
  logic        donevalid_r;
  logic        errvalid_r;
  logic [1:0]  errcode_r;
  logic [31:0] rdata_r;
  logic        breq_r;
  logic        bwe_r;
  logic [31:0] baddr_r;
  logic [31:0] bwdata_r;
  logic [3:0]  bstrb_r;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]  tmo_cnt_r;
`endif

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    end else begin
      bad = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    end
    return bad;
  endfunction

  // Low two funct3 bits give the access width for every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_strb(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    if (!we) begin
      s = 4'b0000;
    end else begin
      case (f3[1:0])
        2'b00:   s = 4'b0001 << off;
        2'b01:   s = 4'b0011 << off;
        default: s = 4'b1111;
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Sequencer state and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      f3_r        <= 3'b000;
      off_r       <= 2'b00;
      busy_r      <= 1'b0;
      donevalid_r <= 1'b0;
      errvalid_r  <= 1'b0;
      errcode_r   <= 2'b00;
      rdata_r     <= 32'h0000_0000;
      breq_r      <= 1'b0;
      bwe_r       <= 1'b0;
      baddr_r     <= 32'h0000_0000;
      bwdata_r    <= 32'h0000_0000;
      bstrb_r     <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_r   <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (memReq) begin
            we_r     <= memWe;
            f3_r     <= funct3;
            off_r    <= addr[1:0];
            baddr_r  <= {addr[31:2], 2'b00};
            bwdata_r <= store_lanes(funct3, wdata);
            bstrb_r  <= store_strb(memWe, funct3, addr[1:0]);
            busy_r   <= 1'b1;
            // Illegal width wins over misalignment; neither touches the bus.
            if (illegal_f3(memWe, funct3)) begin
              state_r    <= ERR;
              errvalid_r <= 1'b1;
              errcode_r  <= 2'b10;
            end else if (misaligned(funct3, addr[1:0])) begin
              state_r    <= ERR;
              errvalid_r <= 1'b1;
              errcode_r  <= 2'b01;
            end else begin
              state_r    <= ISSUE;
              breq_r     <= 1'b1;
              bwe_r      <= memWe;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt_r  <= 8'd0;
`endif
            end
          end
        end
        ISSUE: begin
          if (bus.busAck) begin
            state_r     <= DONE;
            breq_r      <= 1'b0;
            bwe_r       <= 1'b0;
            donevalid_r <= 1'b1;
            if (!we_r) begin
              rdata_r <= load_ext(f3_r, off_r, bus.busRdata);
            end
          end else begin
`ifdef LSU_TIMEOUT_EN
            if (tmo_cnt_r == 8'(TIMEOUT_CYC - 1)) begin
              state_r    <= ERR;
              breq_r     <= 1'b0;
              bwe_r      <= 1'b0;
              errvalid_r <= 1'b1;
              errcode_r  <= 2'b11;
            end else begin
              tmo_cnt_r  <= tmo_cnt_r + 8'd1;
            end
`endif
          end
        end
        DONE: begin
          donevalid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        ERR: begin
          errvalid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          breq_r      <= 1'b0;
          bwe_r       <= 1'b0;
          donevalid_r <= 1'b0;
          errvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign doneValid    = donevalid_r;
  assign rdata        = rdata_r;
  assign errValid     = errvalid_r;
  assign errCode      = errcode_r;
  assign bus.busReq   = breq_r;
  assign bus.busWe    = bwe_r;
  assign bus.busAddr  = baddr_r;
  assign bus.busWdata = bwdata_r;
  assign bus.busStrb  = bstrb_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: an access-level model predicts every output each cycle,
// with literal checks pinning the model on the documented example accesses.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memReq = 1'b0;
  logic        memWe = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, doneValid, errValid;
  logic [31:0] rdata;
  logic [1:0]  errCode;

  lsu_ctrl_if bus_if ();

  lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .memReq(memReq), .memWe(memWe), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .doneValid(doneValid), .rdata(rdata),
    .errValid(errValid), .errCode(errCode), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_on = 1'b0;

  // Expected output values for the current cycle
  logic        e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_breq = 1'b0, e_bwe = 1'b0;
  logic [1:0]  e_code = 2'b00;
  logic [31:0] e_rdata = 32'h0, e_baddr = 32'h0, e_bwdata = 32'h0;
  logic [3:0]  e_bstrb = 4'h0;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_strb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic logic [1:0] err_of(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int  f;
    bit  legal;
    f = int'(f3);
    legal = we ? (f <= 2) : (f != 3 && f < 6);
    if (!legal) return 2'd2;
    if ((a % 32'(size_of(f3))) != 32'd0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    longint bits, v;
    bits = 8 * size_of(f3);
    v = longint'(word) >> (8 * (a % 32'd4));
    v = v % (longint'(1) << bits);
    if (int'(f3) < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  function automatic logic [3:0] strb_of(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << size_of(f3)) - 1) << int'(a % 32'd4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] lanes_of(input logic [2:0] f3, input logic [31:0] d);
    if (size_of(f3) == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
    else if (size_of(f3) == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    else return d;
  endfunction

  // One compare per output on every falling edge
  always @(negedge clk) begin
    if (cmp_on) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("doneValid", 32'(doneValid), 32'(e_done));
      check("errValid", 32'(errValid), 32'(e_err));
      check("errCode", 32'(errCode), 32'(e_code));
      check("rdata", rdata, e_rdata);
      check("busReq", 32'(bus_if.busReq), 32'(e_breq));
      if (e_breq) begin
        check("busWe", 32'(bus_if.busWe), 32'(e_bwe));
        check("busAddr", bus_if.busAddr, e_baddr);
        check("busStrb", 32'(bus_if.busStrb), 32'(e_bstrb));
        if (e_bwe) check("busWdata", bus_if.busWdata, e_bwdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_breq = 1'b0;
  endtask

  // Present one request, then run the bus side until completion or abort
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, input logic [31:0] word);
    logic [1:0] code;
    memWe = we; funct3 = f3; addr = a; wdata = wd; memReq = 1'b1;
    tick();
    memReq = 1'b0; addr = 32'h0;
    code = err_of(we, f3, a);
    if (code != 2'd0) begin
      e_busy = 1'b1; e_err = 1'b1; e_code = code; e_breq = 1'b0;
      tick();
      go_idle();
    end else begin
      e_busy = 1'b1; e_breq = 1'b1; e_bwe = we;
      e_baddr = a & 32'hFFFF_FFFC;
      e_bstrb = we ? strb_of(f3, a) : 4'b0000;
      e_bwdata = lanes_of(f3, wd);
      last_addr = bus_if.busAddr; last_strb = bus_if.busStrb; last_wdata = bus_if.busWdata;
      for (int w = 0; w < dly; w++) begin
        bus_if.busAck = 1'b0;
        bus_if.busRdata = 32'hDEAD_BEEF;
        memReq = (w % 2 == 0);
        addr = 32'h0000_0FF0 + 32'(w);
        funct3 = 3'b011;
        tick();
      end
      memReq = 1'b0; funct3 = f3; addr = 32'h0;
      bus_if.busAck = 1'b1; bus_if.busRdata = word;
      tick();
      bus_if.busAck = 1'b0; bus_if.busRdata = 32'h0;
      e_breq = 1'b0; e_done = 1'b1;
      if (!we) e_rdata = load_val(f3, a, word);
      tick();
      go_idle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    go_idle();
    e_code = 2'b00; e_rdata = 32'h0;
    #1;
    check("rst busReq", 32'(bus_if.busReq), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus_if.busAck = 1'b0;
    bus_if.busRdata = 32'h0;
    tick();
    cmp_on = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_7F01);
    check("LB busAddr", last_addr, 32'h0000_0100);
    check("LB busStrb", 32'(last_strb), 32'h0);
    check("LB rdata", rdata, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_7F01);
    check("LBU rdata", rdata, 32'h0000_0080);
    access(1'b0, 3'b001, 32'h2, 32'h0, 1, 32'h8001_1234);
    check("LH rdata", rdata, 32'hFFFF_8001);
    access(1'b0, 3'b101, 32'h1, 32'h0, 0, 32'h0);
    check("LHU mis code", 32'(errCode), 32'h1);

    access(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 0, 32'h0);
    check("SB strb", 32'(last_strb), 32'h2);
    check("SB wdata", last_wdata, 32'hABAB_ABAB);
    access(1'b1, 3'b001, 32'h12, 32'h1234_CDEF, 2, 32'h0);
    check("SH strb", 32'(last_strb), 32'hC);
    access(1'b1, 3'b010, 32'h10, 32'h1234_5678, 0, 32'h0);
    check("SW strb", 32'(last_strb), 32'hF);
    check("store keeps rdata", rdata, 32'hFFFF_8001);
    access(1'b1, 3'b010, 32'h2, 32'h0, 0, 32'h0);

    access(1'b0, 3'b011, 32'h20, 32'h0, 0, 32'h0);
    check("ld f3=011 code", 32'(errCode), 32'h2);
    access(1'b1, 3'b100, 32'h21, 32'h0, 0, 32'h0);
    check("st f3=100 code", 32'(errCode), 32'h2);

    access(1'b0, 3'b010, 32'h204, 32'h0, 5, 32'hCAFE_F00D);
    check("LW delayed rdata", rdata, 32'hCAFE_F00D);

    // Stray ack while idle must change nothing
    bus_if.busAck = 1'b1; bus_if.busRdata = 32'h1111_1111;
    tick();
    bus_if.busAck = 1'b0;
    tick();

    // Reset in the middle of a wait, then a normal access
    memWe = 1'b0; funct3 = 3'b010; addr = 32'h300; memReq = 1'b1;
    tick();
    memReq = 1'b0;
    e_busy = 1'b1; e_breq = 1'b1; e_bwe = 1'b0; e_baddr = 32'h300; e_bstrb = 4'b0000;
    tick();
    tick();
    do_reset();
    access(1'b0, 3'b001, 32'h6, 32'h0, 0, 32'hFEDC_0042);
    check("post-reset LH", rdata, 32'hFFFF_FEDC);

    // Ack never arrives
    memWe = 1'b0; funct3 = 3'b010; addr = 32'h40; memReq = 1'b1;
    tick();
    memReq = 1'b0;
    e_busy = 1'b1; e_breq = 1'b1; e_bwe = 1'b0; e_baddr = 32'h40; e_bstrb = 4'b0000;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) tick();
    tick();
    e_breq = 1'b0; e_err = 1'b1; e_code = 2'b11;
    tick();
    go_idle();
    bus_if.busAck = 1'b1; bus_if.busRdata = 32'h5555_5555;
    tick();
    bus_if.busAck = 1'b0;
    tick();
    check("timeout code", 32'(errCode), 32'h3);
`else
    for (int i = 0; i < 300; i++) tick();
    check("no-timeout busy", 32'(busy), 32'h1);
    check("no-timeout busReq", 32'(bus_if.busReq), 32'h1);
`endif
    do_reset();
    access(1'b0, 3'b101, 32'h2, 32'h0, 0, 32'h8001_0000);
    check("final LHU", rdata, 32'h0000_8001);
    tick();

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
